stim_sweep: RTL and testbench
=============================

# stim_sweep

Parametrised, synthesizable sweep engine that drives a combinational unit under test with an arithmetic sequence of input codes and captures its responses. It generalises the fixed 12-bit exhaustive `y`/`x = y+1` sweep to a configurable width, range, step, offset and settle time. It adds a start/busy/done handshake, abort, a point counter and an optional response signature. It sits between a bench or on-chip controller and any `f`-style block.

## Interface
- `WIDTH`, 12, width of driven codes `y`/`x`.
- `RESP_W`, 12, width of each DUT response `resp_a`/`resp_b`.
- `OFFSET`, 1, constant added to `y` to form `x` (mod 2^WIDTH).
- `SETTLE`, 1, cycles a code is held before sampling (≥1).

Ports:
- `clk  in  1`  rising-edge clock.
- `rst  in  1`  asynchronous, active-high reset.
- `start  in  1`  begin sweep; sampled only in IDLE.
- `abort  in  1`  cancel sweep; no `done` pulse.
- `range_lo  in  WIDTH`  first code, latched at start.
- `range_hi  in  WIDTH`  last permitted code, latched at start.
- `step  in  WIDTH`  increment, latched at start; 0 treated as 1.
- `y  out  WIDTH`  registered drive code.
- `x  out  WIDTH`  registered `y+OFFSET`, wraps mod 2^WIDTH.
- `resp_a  in  RESP_W`  DUT response A.
- `resp_b  in  RESP_W`  DUT response B.
- `sample_valid  out  1`  one-cycle pulse; responses captured this cycle.
- `busy  out  1`  high from the cycle after start until return to IDLE.
- `done  out  1`  one-cycle pulse after the last sample.
- `count  out  WIDTH+1`  number of points sampled in the current or last sweep.
- `signature  out  2*RESP_W`  response signature (see Configuration).

## Operation
- States: IDLE, DRIVE, SAMPLE, DONE.
- Reset: state IDLE. `y`, `x`, `count` and `signature` are 0. `busy`, `done` and `sample_valid` are 0. Latched range is 0.
- IDLE + `start`:
  - latch lo/hi/step;
  - `y<=range_lo`, `x<=range_lo+OFFSET`;
  - clear `count` and `signature`;
  - load settle counter with SETTLE-1;
  - go to DRIVE.
- DRIVE: decrement settle counter; at 0 go to SAMPLE.
- SAMPLE:
  - `sample_valid=1`;
  - `count<=count+1`;
  - signature update with `resp_a`/`resp_b`.
  - Compute `nxt = y + step` in WIDTH+1 bits.
  - If `y >= hi` or `nxt > hi`: go to DONE.
  - Otherwise `y<=nxt`, `x<=nxt+OFFSET`, reload the settle counter, go to DRIVE.
- DONE: `done=1` for one cycle, then IDLE. `y`, `x`, `count` and `signature` hold their final values.
- `range_lo > range_hi`: exactly one point (lo) is sampled, then DONE.
- Full range (lo=0, hi=2^WIDTH-1, step 1): all 2^WIDTH codes are sampled; `count` reaches 2^WIDTH with no overflow.
- `abort` in DRIVE/SAMPLE/DONE: IDLE next cycle, no `done`, no further sample. `count`/`signature` hold. Abort takes priority over a same-cycle sample.
- `start` while busy: ignored. `start` and `abort` together in IDLE: abort wins, remain IDLE.
- Async `rst` mid-sweep: immediately returns all state and outputs to the reset values.

## Timing
- Start accepted at edge E0. `busy`, `y=lo` and `x` are valid after E0.
- Each point occupies SETTLE cycles in DRIVE plus 1 cycle in SAMPLE. `sample_valid` first rises SETTLE cycles after E0.
- Responses are sampled at the rising edge that ends the SAMPLE cycle. The DUT is combinational, so responses must settle within SETTLE+1 cycles.
- N points: `done` is high during cycle N·(SETTLE+1) after E0. `busy` falls on the following edge.
- `x` and `y` change only at SAMPLE→DRIVE transitions. They are glitch-free from the block's side.

## Configuration
- `STIM_SWEEP_MISR_EN` defined:
  - `signature` is a MISR;
  - on each sample, `sig <= {sig[2*RESP_W-2:0], sig[2*RESP_W-1]} ^ {resp_a, resp_b}`;
  - cleared at start.
- Undefined: no signature logic is built and `signature` is tied to 0. All other behaviour is identical.

## Test plan
- WIDTH=12, SETTLE=1, lo=0, hi=4095, step=1, responses tied to `x`:
  - 4096 `sample_valid` pulses;
  - `x=y+1` at every sample; at y=4095, x=0;
  - `count=4096`;
  - `done` at cycle 8192 after start.
- lo=10, hi=20, step=3, SETTLE=2: samples at y=10, 13, 16, 19; `count=4`; `done` at cycle 12. Repeat with step=0: 11 samples, y=10..20.
- lo=50, hi=20: single sample at y=50, `count=1`, then `done`.
- Abort asserted during the 3rd DRIVE of a step-1 sweep: IDLE next cycle, no `done`, `count=2`. A `start` pulse while busy has no effect.
- With `STIM_SWEEP_MISR_EN`: one point with resp_a=12'h001, resp_b=12'h000 gives signature 24'h001000. Responses held at 0 give signature 0. Without the macro, signature is always 0.
- Assert `rst` mid-sweep: all outputs are 0 and state is IDLE immediately. A `start` after reset release runs a clean sweep.

Source files
------------

// File: rtl/stim_sweep.sv
// Sweep engine: drives y/x = y+OFFSET along lo..hi in steps, holds each code SETTLE cycles, samples responses.
// Build with STIM_SWEEP_MISR_EN defined to get the response MISR; otherwise signature is tied to 0.
module stim_sweep #(
   parameter int WIDTH  = 12,
   parameter int RESP_W = 12,
   parameter int OFFSET = 1,
   parameter int SETTLE = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic [WIDTH-1:0]    range_lo,
   input  logic [WIDTH-1:0]    range_hi,
   input  logic [WIDTH-1:0]    step,
   output logic [WIDTH-1:0]    y,
   output logic [WIDTH-1:0]    x,
   input  logic [RESP_W-1:0]   resp_a,
   input  logic [RESP_W-1:0]   resp_b,
   output logic                sample_valid,
   output logic                busy,
   output logic                done,
   output logic [WIDTH:0]      count,
   output logic [2*RESP_W-1:0] signature
);
   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SW-1:0]    SETTLE_LD = SW'(SETTLE - 1);
   localparam logic [WIDTH-1:0] OFF       = WIDTH'(OFFSET);

   typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  y_q, y_d, x_q, x_d, hi_q, hi_d, step_q, step_d;
   logic [WIDTH:0]    count_q, count_d;
   logic [SW-1:0]     settle_q, settle_d;
   logic [WIDTH:0]    nxt;
   logic              last_pt;
   logic              load;

   // One bit wider than the codes so hi near 2^WIDTH-1 never wraps back into range.
   assign nxt     = {1'b0, y_q} + {1'b0, step_q};
   assign last_pt = (y_q >= hi_q) || (nxt > {1'b0, hi_q});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:   if (start) state_d = S_DRIVE;
            S_DRIVE:  if (settle_q == '0) state_d = S_SAMPLE;
            S_SAMPLE: state_d = last_pt ? S_DONE : S_DRIVE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
         endcase
      end
   end

   // Abort masks the pulses of the cycle it arrives in, so no sample or done escapes.
   always_comb begin
      busy         = (state_q != S_IDLE);
      sample_valid = (state_q == S_SAMPLE) && !abort;
      done         = (state_q == S_DONE) && !abort;
      load         = (state_q == S_IDLE) && start && !abort;
   end

   always_comb begin
      hi_d     = hi_q;
      step_d   = step_q;
      y_d      = y_q;
      x_d      = x_q;
      count_d  = count_q;
      settle_d = settle_q;
      if (load) begin
         hi_d     = range_hi;
         step_d   = (step == '0) ? WIDTH'(1) : step;
         y_d      = range_lo;
         x_d      = range_lo + OFF;
         count_d  = '0;
         settle_d = SETTLE_LD;
      end else if ((state_q == S_DRIVE) && !abort && (settle_q != '0)) begin
         settle_d = settle_q - SW'(1);
      end else if (sample_valid) begin
         count_d = count_q + (WIDTH+1)'(1);
         if (!last_pt) begin
            y_d      = nxt[WIDTH-1:0];
            x_d      = nxt[WIDTH-1:0] + OFF;
            settle_d = SETTLE_LD;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_q     <= '0;
         step_q   <= '0;
         y_q      <= '0;
         x_q      <= '0;
         count_q  <= '0;
         settle_q <= '0;
      end else begin
         hi_q     <= hi_d;
         step_q   <= step_d;
         y_q      <= y_d;
         x_q      <= x_d;
         count_q  <= count_d;
         settle_q <= settle_d;
      end
   end

   assign y     = y_q;
   assign x     = x_q;
   assign count = count_q;

`ifdef STIM_SWEEP_MISR_EN
   logic [2*RESP_W-1:0] sig_q, sig_d;

   always_comb begin
      sig_d = sig_q;
      if (load) begin
         sig_d = '0;
      end else if (sample_valid) begin
         sig_d = {sig_q[2*RESP_W-2:0], sig_q[2*RESP_W-1]} ^ {resp_a, resp_b};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig_q <= '0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign signature = sig_q;
`else
   logic unused_resp;
   assign unused_resp = ^{resp_a, resp_b};
   assign signature   = '0;
`endif

endmodule

// File: tb/tb_stim_sweep.sv
// Scoreboard bench for stim_sweep: the driver pushes expected samples/done events, a monitor pops and compares.
module tb_stim_sweep;
   localparam int W   = 12;
   localparam int RW  = 12;
   localparam int OFF = 1;
   localparam int ST  = 2;

   logic           clk = 1'b0;
   logic           rst, start, abort;
   logic [W-1:0]   range_lo, range_hi, step, y, x;
   logic [RW-1:0]  resp_a, resp_b;
   logic           sample_valid, busy, done;
   logic [W:0]     count;
   logic [2*RW-1:0] signature;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   logic          resp_const;
   logic [RW-1:0] ka, kb;

   typedef struct {int yv; int xv; int idx;} samp_t;
   typedef struct {int n; logic [2*RW-1:0] sig; int cyc;} done_t;
   samp_t exp_s[$];
   done_t exp_d[$];

   stim_sweep #(.WIDTH(W), .RESP_W(RW), .OFFSET(OFF), .SETTLE(ST)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .range_lo(range_lo), .range_hi(range_hi), .step(step),
      .y(y), .x(x), .resp_a(resp_a), .resp_b(resp_b),
      .sample_valid(sample_valid), .busy(busy), .done(done),
      .count(count), .signature(signature)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in combinational unit under test.
   assign resp_a = resp_const ? ka : (x * 12'd5 + ka);
   assign resp_b = resp_const ? kb : (y ^ kb);

   function automatic logic [RW-1:0] ra(input int xv);
      logic [RW-1:0] r;
      r = RW'(xv * 5 + int'(ka));
      return resp_const ? ka : r;
   endfunction

   function automatic logic [RW-1:0] rb(input int yv);
      logic [RW-1:0] r;
      r = RW'(yv) ^ kb;
      return resp_const ? kb : r;
   endfunction

   function automatic logic [2*RW-1:0] misr(input logic [2*RW-1:0] s, input logic [RW-1:0] a,
                                            input logic [RW-1:0] b);
      logic [2*RW-1:0] rot;
      rot = (s << 1) | (s >> (2*RW-1));
      return rot ^ {a, b};
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: the list of points is lo, lo+s, ... while staying <= hi; at least lo is always sampled.
   task automatic build(input int lo, input int hi, input int st, input int maxn,
                        output int n, output logic [2*RW-1:0] sig);
      int s, yv;
      samp_t e;
      s   = (st == 0) ? 1 : st;
      yv  = lo;
      n   = 0;
      sig = '0;
      while (n < maxn) begin
         e.yv  = yv;
         e.xv  = (yv + OFF) % (1 << W);
         e.idx = n;
         exp_s.push_back(e);
         sig = misr(sig, ra(e.xv), rb(yv));
         n++;
         if (yv >= hi || yv + s > hi) break;
         yv += s;
      end
`ifndef STIM_SWEEP_MISR_EN
      sig = '0;
`endif
   endtask

   task automatic issue_start(input int lo, input int hi, input int st, output int e0);
      @(negedge clk);
      range_lo = W'(lo);
      range_hi = W'(hi);
      step     = W'(st);
      start    = 1'b1;
      @(posedge clk);
      #1;
      e0       = cyc;
      start    = 1'b0;
      range_lo = W'($urandom);
      range_hi = W'($urandom);
      step     = W'($urandom);
      check("busy_after_start", busy, 1);
      check("y_after_start", y, lo);
      check("x_after_start", x, (lo + OFF) % (1 << W));
   endtask

   task automatic run_sweep(input int lo, input int hi, input int st);
      int n, e0, k;
      logic [2*RW-1:0] sig;
      done_t d;
      build(lo, hi, st, 1 << 20, n, sig);
      issue_start(lo, hi, st, e0);
      d.n   = n;
      d.sig = sig;
      d.cyc = e0 + n * (ST + 1);
      exp_d.push_back(d);
      // A start while busy must not disturb the sweep.
      @(negedge clk);
      range_lo = W'($urandom);
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      k = 0;
      #2;
      while (busy !== 1'b0 && k < n * (ST + 1) + 20) begin
         @(negedge clk);
         #2;
         k++;
      end
      check("sweep_returns_idle", busy, 0);
      check("count_held", count, n);
      check("signature_held", signature, sig);
      check("samples_drained", exp_s.size(), 0);
      check("done_drained", exp_d.size(), 0);
      exp_s.delete();
      exp_d.delete();
   endtask

   task automatic run_abort(input int lo, input int hi, input int st, input int off, input int nexp);
      int n, e0;
      logic [2*RW-1:0] sig;
      build(lo, hi, st, nexp, n, sig);
      issue_start(lo, hi, st, e0);
      while (cyc < e0 + off) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      #2;
      check("abort_idle", busy, 0);
      check("abort_count", count, nexp);
      check("abort_signature", signature, sig);
      check("abort_samples_drained", exp_s.size(), 0);
      exp_s.delete();
   endtask

   // Monitor: pops the scoreboard on every sample/done pulse.
   always begin
      samp_t e;
      done_t d;
      @(negedge clk);
      #1;
      if (sample_valid === 1'b1) begin
         if (exp_s.size() == 0) begin
            check("unexpected_sample", 1, 0);
         end else begin
            e = exp_s.pop_front();
            check("sample_y", y, e.yv);
            check("sample_x", x, e.xv);
            check("sample_count", count, e.idx);
         end
      end
      if (done === 1'b1) begin
         if (exp_d.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            d = exp_d.pop_front();
            check("done_count", count, d.n);
            check("done_signature", signature, d.sig);
            check("done_cycle", cyc, d.cyc);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation still running at cycle %0d, required finish", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int e0, n;
      int lo, hi, st;
      logic [2*RW-1:0] sig, exp_sig;
      rst = 1'b0; start = 1'b0; abort = 1'b0;
      range_lo = '0; range_hi = '0; step = '0;
      resp_const = 1'b0; ka = 12'h3a5; kb = 12'h0c3;
      #2 rst = 1'b1;
      #1;
      check("rst_y", y, 0);
      check("rst_x", x, 0);
      check("rst_count", count, 0);
      check("rst_signature", signature, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sample_valid", sample_valid, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      run_sweep(10, 20, 3);
      run_sweep(10, 20, 0);
      run_sweep(50, 20, 5);

      resp_const = 1'b1; ka = 12'h001; kb = 12'h000;
      run_sweep(50, 20, 1);
      exp_sig = '0;
`ifdef STIM_SWEEP_MISR_EN
      exp_sig = 24'h001000;
`endif
      check("misr_single_point", signature, exp_sig);
      ka = 12'h000;
      run_sweep(0, 30, 7);
      check("misr_zero_resp", signature, 0);
      resp_const = 1'b0;

      run_sweep(4090, 4095, 4);
      run_sweep(4093, 4095, 3000);

      for (int i = 0; i < 6; i++) begin
         ka = RW'($urandom);
         kb = RW'($urandom);
         lo = int'($urandom_range(0, 4095));
         hi = (i == 2) ? int'($urandom_range(0, 4095)) : lo + int'($urandom_range(0, 300));
         if (hi > 4095) hi = 4095;
         st = int'($urandom_range(0, 40));
         run_sweep(lo, hi, st);
      end

      run_abort(100, 200, 1, 6, 2);
      run_abort(100, 200, 1, 8, 2);
      run_abort(5, 6, 1, 6, 2);

      @(negedge clk);
      range_lo = 12'd777; start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      #2;
      check("start_abort_idle", busy, 0);
      check("start_abort_y_held", y, 6);

      build(0, 4095, 1, 1, n, sig);
      issue_start(0, 4095, 1, e0);
      while (cyc < e0 + 4) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_y", y, 0);
      check("midrst_x", x, 0);
      check("midrst_count", count, 0);
      check("midrst_signature", signature, 0);
      check("midrst_busy", busy, 0);
      check("midrst_sample_valid", sample_valid, 0);
      check("midrst_done", done, 0);
      check("midrst_samples_drained", exp_s.size(), 0);
      exp_s.delete();
      @(negedge clk);
      rst = 1'b0;
      run_sweep(0, 15, 1);

      ka = 12'h000; kb = 12'h000;
      run_sweep(0, 4095, 1);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
